tc_acquire_arbiter: RTL and testbench
=====================================

Name: tc_acquire_arbiter

Overview:
- Shares the single TileLink acquire/grant/finish port of the tag cache (TagCacheTop io_in_*) between NREQ independent requesters, such as core trace players or DMA engines.
- Arbitrates acquires round-robin and holds the lock for multi-beat bursts.
- Tags each client_xact_id with the requester index, routes grant beats back by that index, caps per-requester outstanding transactions, and issues finish messages on behalf of requesters.

Parameters:
- NREQ, 4, number of requesters (power of 2, 2..8)
- IDXW, $clog2(NREQ), requester index width
- XIDW, 5, per-requester transaction-id width; downstream client_xact_id width = IDXW+XIDW (7 at defaults)
- ADDRW, 26, acquire addr_block width
- DATAW, 64, beat data width
- TAGW, 4, tag bits per beat
- MIDW, 2, manager_xact_id width
- MAXOUT, 4, max outstanding acquires per requester
- FINDEPTH, 2, finish FIFO depth

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester acquire beat valid
- req_ready  out  NREQ  per-requester acquire beat accepted
- req_last  in  NREQ  beat is last of acquire (1 for single-beat)
- req_addr  in  NREQ*ADDRW  addr_block
- req_xid  in  NREQ*XIDW  requester transaction id
- req_beat  in  NREQ*3  addr_beat
- req_atype  in  NREQ*16  {union,a_type}
- req_data  in  NREQ*DATAW  put data
- req_tag  in  NREQ*TAGW  put tag
- acq_valid / acq_ready  out / in  1  downstream acquire handshake
- acq_addr, acq_xid, acq_beat, acq_atype, acq_data, acq_tag  out  ADDRW, IDXW+XIDW, 3, 16, DATAW, TAGW  muxed acquire fields
- gnt_valid / gnt_ready  in / out  1  downstream grant handshake
- gnt_xid  in  IDXW+XIDW  grant client_xact_id
- gnt_last  in  1  last grant beat
- gnt_need_finish  in  1  grant requires finish (sampled on last beat)
- gnt_mid  in  MIDW  manager_xact_id
- rsp_valid  out  NREQ  one-hot grant beat valid to requester
- rsp_ready  in  NREQ  requester grant ready
- rsp_xid  out  XIDW  low bits of gnt_xid
- fin_valid / fin_ready  out / in  1  downstream finish handshake
- fin_mid  out  MIDW  finish manager_xact_id
- err  out  1  sticky protocol error

Behaviour:
- Reset (rstn=0 at posedge): rr_ptr=0, lock clear, all outstanding counters 0, finish FIFO empty, err=0. All valid/ready outputs read 0 while rstn=0. A burst in progress at reset is abandoned.
- Eligible(i) = req_valid[i] && (cnt[i] < MAXOUT || lock owned by i).
- Unlocked: winner = first eligible index at or after rr_ptr, modulo NREQ; selection is combinational, so there is zero added latency.
- acq_valid = winner exists; acq_* are muxed from the winner; acq_xid = {winner, req_xid[winner]}.
- req_ready[winner] = acq_ready; every other bit is 0.
- On accepted beat with req_last=0: lock := winner. While locked, only the owner is selected, ignoring the MAXOUT mask.
- On accepted beat with req_last=1: lock cleared, rr_ptr := winner+1 (wraps), cnt[winner]++.
- Grant path: i = gnt_xid[IDXW+XIDW-1:XIDW]; rsp_valid = onehot(i) & gnt_valid; rsp_xid = gnt_xid[XIDW-1:0].
- fin_block = gnt_last && gnt_need_finish && FIFO full.
- gnt_ready = rsp_ready[i] && !fin_block.
- On grant fire with gnt_last: cnt[i]--. If gnt_need_finish, push gnt_mid into the FIFO.
- Finish FIFO: fin_valid = !empty; fin_mid = head; pop on fin_valid && fin_ready. Simultaneous push and pop when full is not allowed (gnt_ready already 0); push and pop when non-empty are both performed.
- Same requester, acquire-last and grant-last in the same cycle: cnt unchanged.
- err set (sticky until reset) when a grant-last fires for i with cnt[i]==0, or when i >= NREQ; that counter saturates at 0.
- Counters are $clog2(MAXOUT+1) bits wide and never exceed MAXOUT.

Decomposition:
- Package tc_arb_pkg: a_type and g_type constants, beat count (8), and a function to compute the client_xact_id width.
- Sub-module tc_finish_fifo: parameterised FINDEPTH x MIDW synchronous FIFO with full/empty outputs.

Test Plan:
- Reset then idle: all outputs 0 and err=0; after reset release with no requests, acq_valid=0.
- Req0 and req2 both valid with single-beat gets, rr_ptr=0 -> req0 granted (acq_xid={0,xid}) then req2; next round starts at 3.
- Req1 sends an 8-beat put while req3 is valid -> 8 consecutive req1 beats with no interleave, then req3.
- Req0 issues 4 gets with no grants (MAXOUT=4) -> 5th get held; one grant-last returns -> 5th accepted the following cycle.
- Three grants needing finish with fin_ready=0 -> first two are pushed, third grant stalls (gnt_ready=0); fin_ready=1 -> finishes emitted in order and the third is accepted.
- Grant-last for req2 with cnt=0 -> err=1 and stays 1 until rstn=0.

Source files
------------

// File: rtl/tc_arb_pkg.sv
// Shared types and constants for the tag-cache acquire arbiter.
package tc_arb_pkg;

    localparam int BEATS  = 8;
    localparam int BEATW  = 3;
    localparam int ATYPEW = 16;

    typedef enum logic [2:0] {
        A_GET          = 3'd0,
        A_GET_BLOCK    = 3'd1,
        A_PUT          = 3'd2,
        A_PUT_BLOCK    = 3'd3,
        A_PUT_ATOMIC   = 3'd4,
        A_GET_PREFETCH = 3'd5,
        A_PUT_PREFETCH = 3'd6
    } a_type_e;

    typedef enum logic [3:0] {
        G_VOLUNTARY_ACK  = 4'd0,
        G_PREFETCH_ACK   = 4'd1,
        G_PUT_ACK        = 4'd3,
        G_GET_DATA_BEAT  = 4'd4,
        G_GET_DATA_BLOCK = 4'd5
    } g_type_e;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_e;

    // Downstream client_xact_id = {requester index, requester xid}.
    function automatic int xact_id_width(input int nreq, input int xidw);
        return $clog2(nreq) + xidw;
    endfunction

endpackage

// File: rtl/tc_acquire_arbiter_if.sv
// Bundle of requester, acquire, grant and finish signals around the arbiter.
interface tc_acquire_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int XIDW  = 5,
    parameter int ADDRW = 26,
    parameter int DATAW = 64,
    parameter int TAGW  = 4,
    parameter int MIDW  = 2
);
    import tc_arb_pkg::*;

    logic [NREQ-1:0]                       req_valid;
    logic [NREQ-1:0]                       req_ready;
    logic [NREQ-1:0]                       req_last;
    logic [NREQ*ADDRW-1:0]                 req_addr;
    logic [NREQ*XIDW-1:0]                  req_xid;
    logic [NREQ*BEATW-1:0]                 req_beat;
    logic [NREQ*ATYPEW-1:0]                req_atype;
    logic [NREQ*DATAW-1:0]                 req_data;
    logic [NREQ*TAGW-1:0]                  req_tag;

    logic                                  acq_valid;
    logic                                  acq_ready;
    logic [ADDRW-1:0]                      acq_addr;
    logic [xact_id_width(NREQ, XIDW)-1:0]  acq_xid;
    logic [BEATW-1:0]                      acq_beat;
    logic [ATYPEW-1:0]                     acq_atype;
    logic [DATAW-1:0]                      acq_data;
    logic [TAGW-1:0]                       acq_tag;

    logic                                  gnt_valid;
    logic                                  gnt_ready;
    logic [xact_id_width(NREQ, XIDW)-1:0]  gnt_xid;
    logic                                  gnt_last;
    logic                                  gnt_need_finish;
    logic [MIDW-1:0]                       gnt_mid;

    logic [NREQ-1:0]                       rsp_valid;
    logic [NREQ-1:0]                       rsp_ready;
    logic [XIDW-1:0]                       rsp_xid;

    logic                                  fin_valid;
    logic                                  fin_ready;
    logic [MIDW-1:0]                       fin_mid;

    logic                                  err;

    // Arbiter side.
    modport slave (
        input  req_valid, req_last, req_addr, req_xid, req_beat, req_atype, req_data, req_tag,
        output req_ready,
        output acq_valid, acq_addr, acq_xid, acq_beat, acq_atype, acq_data, acq_tag,
        input  acq_ready,
        input  gnt_valid, gnt_xid, gnt_last, gnt_need_finish, gnt_mid,
        output gnt_ready,
        output rsp_valid, rsp_xid,
        input  rsp_ready,
        output fin_valid, fin_mid,
        input  fin_ready,
        output err
    );

    // Requesters plus the tag cache.
    modport master (
        output req_valid, req_last, req_addr, req_xid, req_beat, req_atype, req_data, req_tag,
        input  req_ready,
        input  acq_valid, acq_addr, acq_xid, acq_beat, acq_atype, acq_data, acq_tag,
        output acq_ready,
        output gnt_valid, gnt_xid, gnt_last, gnt_need_finish, gnt_mid,
        input  gnt_ready,
        input  rsp_valid, rsp_xid,
        output rsp_ready,
        input  fin_valid, fin_mid,
        output fin_ready,
        input  err
    );

endinterface

// File: rtl/tc_finish_fifo.sv
// Small synchronous FIFO holding manager_xact_ids that still owe a finish.
module tc_finish_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_q, wr_d;
    logic [PTRW-1:0]  rd_q, rd_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next state; push and pop may happen together.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = ptr_next(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_next(rd_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    // Pointer/occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tc_acquire_arbiter.sv
// Round-robin sharing of the tag-cache acquire/grant/finish port among NREQ requesters.
module tc_acquire_arbiter
    import tc_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDXW     = $clog2(NREQ),
    parameter int XIDW     = 5,
    parameter int ADDRW    = 26,
    parameter int DATAW    = 64,
    parameter int TAGW     = 4,
    parameter int MIDW     = 2,
    parameter int MAXOUT   = 4,
    parameter int FINDEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    tc_acquire_arbiter_if.slave bus
);

    localparam int CXIDW = xact_id_width(NREQ, XIDW);
    localparam int CNTW  = $clog2(MAXOUT + 1);

    arb_state_e                 state_q, state_d;
    logic [IDXW-1:0]            owner_q, owner_d;
    logic [IDXW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0][CNTW-1:0]  cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic [NREQ-1:0]            elig;
    logic                       found;
    logic [IDXW-1:0]            win;
    logic                       acq_fire;

    logic [IDXW-1:0]            gidx;
    logic                       gidx_ok;
    logic                       gnt_ready_int;
    logic                       gnt_fire;
    logic                       fin_block;
    logic                       fin_push;
    logic                       fin_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [MIDW-1:0]            fifo_head;

    logic [NREQ-1:0]            inc_vec;
    logic [NREQ-1:0]            dec_vec;

    // A requester may start a new transaction only below its outstanding cap.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] && (cnt_q[i] < CNTW'(MAXOUT));
        end
    end

    // Winner: the burst owner while locked, else first eligible at or after rr_ptr.
    always_comb begin
        logic [IDXW-1:0] cand;
        cand  = '0;
        found = 1'b0;
        win   = '0;
        if (state_q == ARB_LOCKED) begin
            found = bus.req_valid[owner_q];
            win   = owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = rr_ptr_q + IDXW'(k);
                if (!found && elig[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    assign acq_fire = rstn && found && bus.acq_ready;

    // Acquire fields are muxed straight from the winner, no added latency.
    always_comb begin
        bus.acq_valid  = rstn && found;
        bus.acq_addr   = bus.req_addr [int'(win)*ADDRW  +: ADDRW];
        bus.acq_xid    = {win, bus.req_xid[int'(win)*XIDW +: XIDW]};
        bus.acq_beat   = bus.req_beat [int'(win)*BEATW  +: BEATW];
        bus.acq_atype  = bus.req_atype[int'(win)*ATYPEW +: ATYPEW];
        bus.acq_data   = bus.req_data [int'(win)*DATAW  +: DATAW];
        bus.acq_tag    = bus.req_tag  [int'(win)*TAGW   +: TAGW];
        bus.req_ready  = '0;
        bus.req_ready[win] = acq_fire;
    end

    // Lock on a non-last beat; a last beat releases the lock and advances rr_ptr.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (acq_fire) begin
            if (bus.req_last[win]) begin
                state_d  = ARB_OPEN;
                rr_ptr_d = win + IDXW'(1);
            end else begin
                state_d  = ARB_LOCKED;
                owner_d  = win;
            end
        end
    end

    // Grant beats are routed by the index carried in the upper xid bits.
    assign gidx          = bus.gnt_xid[CXIDW-1:XIDW];
    assign gidx_ok       = (int'(gidx) < NREQ);
    assign fin_block     = bus.gnt_last && bus.gnt_need_finish && fifo_full;
    assign gnt_ready_int = rstn && bus.rsp_ready[gidx] && !fin_block;
    assign gnt_fire      = bus.gnt_valid && gnt_ready_int;
    assign fin_push      = gnt_fire && bus.gnt_last && bus.gnt_need_finish;
    assign fin_pop       = bus.fin_valid && bus.fin_ready;

    // Grant-side outputs toward the requesters and the cache.
    always_comb begin
        bus.gnt_ready = gnt_ready_int;
        bus.rsp_valid = (rstn && bus.gnt_valid) ? (NREQ'(1) << gidx) : '0;
        bus.rsp_xid   = bus.gnt_xid[XIDW-1:0];
        bus.fin_valid = rstn && !fifo_empty;
        bus.fin_mid   = fifo_head;
        bus.err       = err_q;
    end

    // Per-requester transaction open/close events for this cycle.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (acq_fire && bus.req_last[win]) begin
            inc_vec[win] = 1'b1;
        end
        if (gnt_fire && bus.gnt_last && gidx_ok) begin
            dec_vec[gidx] = 1'b1;
        end
    end

    // Outstanding counters; a close with nothing open flags err and saturates at 0.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int i = 0; i < NREQ; i++) begin
            if (dec_vec[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
                if (inc_vec[i]) begin
                    cnt_d[i] = cnt_q[i] + CNTW'(1);
                end
            end else if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
        end
        if (gnt_fire && bus.gnt_last && !gidx_ok) begin
            err_d = 1'b1;
        end
    end

    // Arbiter state registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ARB_OPEN;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    tc_finish_fifo #(
        .DEPTH (FINDEPTH),
        .WIDTH (MIDW)
    ) u_finish_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fin_push),
        .data_i  (bus.gnt_mid),
        .pop_i   (fin_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_tc_acquire_arbiter.sv
// Directed scoreboard bench for tc_acquire_arbiter.
module tb_tc_acquire_arbiter;
    import tc_arb_pkg::*;

    localparam int NREQ     = 4;
    localparam int XIDW     = 5;
    localparam int ADDRW    = 26;
    localparam int DATAW    = 64;
    localparam int TAGW     = 4;
    localparam int MIDW     = 2;
    localparam int MAXOUT   = 4;
    localparam int FINDEPTH = 2;

    typedef struct {
        logic [6:0]  xid;
        logic [25:0] addr;
        logic [2:0]  beat;
        logic [63:0] data;
    } acqExp_t;

    typedef struct {
        logic [3:0] onehot;
        logic [4:0] xid;
    } rspExp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    acqExp_t    expAcq[$];
    rspExp_t    expRsp[$];
    logic [1:0] expFin[$];

    always #5 clk = ~clk;

    tc_acquire_arbiter_if #(
        .NREQ(NREQ), .XIDW(XIDW), .ADDRW(ADDRW), .DATAW(DATAW), .TAGW(TAGW), .MIDW(MIDW)
    ) bus ();

    tc_acquire_arbiter #(
        .NREQ(NREQ), .XIDW(XIDW), .ADDRW(ADDRW), .DATAW(DATAW), .TAGW(TAGW),
        .MIDW(MIDW), .MAXOUT(MAXOUT), .FINDEPTH(FINDEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string why);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    task automatic expectAcq(input logic [6:0] xid, input logic [25:0] addr, input logic [2:0] beat, input logic [63:0] data);
        acqExp_t e;
        e.xid = xid; e.addr = addr; e.beat = beat; e.data = data;
        expAcq.push_back(e);
    endtask

    task automatic applyStimulus(input int i, input logic [4:0] xid, input logic [25:0] addr, input logic [2:0] beat,
                                 input logic last, input logic [15:0] atype, input logic [63:0] data);
        bus.req_valid[i]                 = 1'b1;
        bus.req_last[i]                  = last;
        bus.req_xid[i*XIDW +: XIDW]      = xid;
        bus.req_addr[i*ADDRW +: ADDRW]   = addr;
        bus.req_beat[i*3 +: 3]           = beat;
        bus.req_atype[i*16 +: 16]        = atype;
        bus.req_data[i*DATAW +: DATAW]   = data;
        bus.req_tag[i*TAGW +: TAGW]      = 4'(i);
    endtask

    task automatic clearReq(input int i);
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(input int i);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready[i]) reportFail("accept_timeout", $sformatf("requester %0d never accepted", i));
        stepClk();
    endtask

    task automatic driveGrant(input logic [6:0] xid, input logic last, input logic needFin, input logic [1:0] mid);
        bus.gnt_valid       = 1'b1;
        bus.gnt_xid         = xid;
        bus.gnt_last        = last;
        bus.gnt_need_finish = needFin;
        bus.gnt_mid         = mid;
    endtask

    task automatic waitGrantFire();
        int n = 0;
        @(negedge clk);
        while (!bus.gnt_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.gnt_ready) reportFail("grant_timeout", "grant never accepted");
        stepClk();
        bus.gnt_valid = 1'b0;
    endtask

    task automatic issueGrant(input logic [6:0] xid, input logic last, input logic needFin, input logic [1:0] mid,
                              input logic [3:0] expOnehot, input logic [4:0] expXid);
        rspExp_t r;
        r.onehot = expOnehot;
        r.xid    = expXid;
        expRsp.push_back(r);
        if (last && needFin) expFin.push_back(mid);
        driveGrant(xid, last, needFin, mid);
        waitGrantFire();
    endtask

    // Monitor: every handshake the DUT presents is matched against the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.acq_valid && bus.acq_ready) begin
                if (expAcq.size() == 0) begin
                    reportFail("acq_unexpected", $sformatf("xid %0h addr %0h", bus.acq_xid, bus.acq_addr));
                end else begin
                    acqExp_t e;
                    e = expAcq.pop_front();
                    checkOutput("acq_xid",  64'(bus.acq_xid),  64'(e.xid));
                    checkOutput("acq_addr", 64'(bus.acq_addr), 64'(e.addr));
                    checkOutput("acq_beat", 64'(bus.acq_beat), 64'(e.beat));
                    checkOutput("acq_data", bus.acq_data, e.data);
                end
            end
            if (bus.gnt_valid && bus.gnt_ready) begin
                if (expRsp.size() == 0) begin
                    reportFail("rsp_unexpected", $sformatf("rsp_valid %0h", bus.rsp_valid));
                end else begin
                    rspExp_t r;
                    r = expRsp.pop_front();
                    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(r.onehot));
                    checkOutput("rsp_xid",   64'(bus.rsp_xid),   64'(r.xid));
                end
            end
            if (bus.fin_valid && bus.fin_ready) begin
                if (expFin.size() == 0) begin
                    reportFail("fin_unexpected", $sformatf("fin_mid %0h", bus.fin_mid));
                end else begin
                    logic [1:0] m;
                    m = expFin.pop_front();
                    checkOutput("fin_mid", 64'(bus.fin_mid), 64'(m));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0; bus.req_last = '0; bus.req_addr = '0; bus.req_xid = '0;
        bus.req_beat = '0; bus.req_atype = '0; bus.req_data = '0; bus.req_tag = '0;
        bus.acq_ready = 1'b1;
        bus.gnt_valid = 1'b1; bus.gnt_xid = 7'h00; bus.gnt_last = 1'b1;
        bus.gnt_need_finish = 1'b0; bus.gnt_mid = '0;
        bus.rsp_ready = '1; bus.fin_ready = 1'b1;
        bus.req_valid = 4'b0101;

        // Reset: outputs quiet even with requests and a grant present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_acq_valid", 64'(bus.acq_valid), 64'd0);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_gnt_ready", 64'(bus.gnt_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_fin_valid", 64'(bus.fin_valid), 64'd0);
        checkOutput("rst_err",       64'(bus.err),       64'd0);
        stepClk();
        bus.req_valid = '0; bus.gnt_valid = 1'b0; bus.gnt_last = 1'b0;
        rstn = 1'b1;
        stepClk();
        @(negedge clk);
        checkOutput("idle_acq_valid", 64'(bus.acq_valid), 64'd0);
        stepClk();

        // Round robin: req0 then req2, next round starts at 3.
        expectAcq(7'h03, 26'h100, 3'd0, 64'd0);
        expectAcq(7'h49, 26'h200, 3'd0, 64'd0);
        applyStimulus(0, 5'd3, 26'h100, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        applyStimulus(2, 5'd9, 26'h200, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        waitAccept(0); clearReq(0);
        waitAccept(2); clearReq(2);
        expectAcq(7'h71, 26'h300, 3'd0, 64'd0);
        expectAcq(7'h04, 26'h104, 3'd0, 64'd0);
        applyStimulus(0, 5'd4,  26'h104, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        applyStimulus(3, 5'd17, 26'h300, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        waitAccept(3); clearReq(3);
        waitAccept(0); clearReq(0);
        issueGrant(7'h03, 1'b1, 1'b0, 2'd0, 4'b0001, 5'd3);
        issueGrant(7'h04, 1'b1, 1'b0, 2'd0, 4'b0001, 5'd4);
        issueGrant(7'h49, 1'b1, 1'b0, 2'd0, 4'b0100, 5'd9);
        issueGrant(7'h71, 1'b1, 1'b0, 2'd0, 4'b1000, 5'd17);

        // 8-beat put from req1 is not interleaved with a waiting req3.
        applyStimulus(3, 5'd18, 26'h310, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        for (int b = 0; b < BEATS; b++) begin
            expectAcq(7'h26, 26'h180, 3'(b), 64'hD00D_0000_0000_0000 + 64'(b));
            applyStimulus(1, 5'd6, 26'h180, 3'(b), (b == BEATS - 1), {13'd0, A_PUT_BLOCK},
                          64'hD00D_0000_0000_0000 + 64'(b));
            waitAccept(1);
        end
        clearReq(1);
        expectAcq(7'h72, 26'h310, 3'd0, 64'd0);
        waitAccept(3); clearReq(3);
        issueGrant(7'h26, 1'b1, 1'b0, 2'd0, 4'b0010, 5'd6);
        issueGrant(7'h72, 1'b0, 1'b0, 2'd0, 4'b1000, 5'd18);
        issueGrant(7'h72, 1'b1, 1'b0, 2'd0, 4'b1000, 5'd18);

        // Outstanding cap: 5th get from req0 waits for one grant-last.
        for (int j = 0; j < MAXOUT; j++) begin
            expectAcq(7'(j), 26'h400 + 26'(j), 3'd0, 64'd0);
            applyStimulus(0, 5'(j), 26'h400 + 26'(j), 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
            waitAccept(0);
        end
        expectAcq(7'h04, 26'h404, 3'd0, 64'd0);
        applyStimulus(0, 5'd4, 26'h404, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("maxout_held_ready", 64'(bus.req_ready[0]), 64'd0);
            checkOutput("maxout_held_valid", 64'(bus.acq_valid), 64'd0);
        end
        stepClk();
        expRsp.push_back('{onehot: 4'b0001, xid: 5'd0});
        driveGrant(7'h00, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("maxout_grant_ready", 64'(bus.gnt_ready), 64'd1);
        checkOutput("maxout_same_cycle", 64'(bus.acq_valid), 64'd0);
        stepClk();
        bus.gnt_valid = 1'b0;
        @(negedge clk);
        checkOutput("maxout_release", 64'(bus.req_ready[0]), 64'd1);
        stepClk();
        clearReq(0);
        for (int j = 1; j <= MAXOUT; j++) begin
            issueGrant(7'(j), 1'b1, 1'b0, 2'd0, 4'b0001, 5'(j));
        end

        // Finish FIFO back-pressure on a third grant needing finish.
        for (int j = 0; j < 3; j++) begin
            expectAcq(7'h4A + 7'(j), 26'h500 + 26'(j), 3'd0, 64'd0);
            applyStimulus(2, 5'd10 + 5'(j), 26'h500 + 26'(j), 3'd0, 1'b1, {13'd0, A_GET_BLOCK}, 64'd0);
            waitAccept(2);
        end
        clearReq(2);
        bus.fin_ready = 1'b0;
        issueGrant(7'h4A, 1'b1, 1'b1, 2'd1, 4'b0100, 5'd10);
        issueGrant(7'h4B, 1'b1, 1'b1, 2'd2, 4'b0100, 5'd11);
        expRsp.push_back('{onehot: 4'b0100, xid: 5'd12});
        expFin.push_back(2'd3);
        driveGrant(7'h4C, 1'b1, 1'b1, 2'd3);
        repeat (3) begin
            @(negedge clk);
            checkOutput("fin_stall_gnt_ready", 64'(bus.gnt_ready), 64'd0);
            checkOutput("fin_stall_fin_valid", 64'(bus.fin_valid), 64'd1);
        end
        stepClk();
        bus.fin_ready = 1'b1;
        waitGrantFire();
        repeat (4) stepClk();
        @(negedge clk);
        checkOutput("fin_drained", 64'(bus.fin_valid), 64'd0);
        stepClk();

        // Grant-last for req2 with nothing open: sticky err until reset.
        checkOutput("err_before", 64'(bus.err), 64'd0);
        issueGrant(7'h4D, 1'b1, 1'b0, 2'd0, 4'b0100, 5'd13);
        @(negedge clk);
        checkOutput("err_set", 64'(bus.err), 64'd1);
        repeat (4) stepClk();
        @(negedge clk);
        checkOutput("err_sticky", 64'(bus.err), 64'd1);
        stepClk();
        rstn = 1'b0;
        stepClk();
        @(negedge clk);
        checkOutput("err_cleared", 64'(bus.err), 64'd0);
        stepClk();
        rstn = 1'b1;

        // Reset restarts round robin at requester 0.
        expectAcq(7'h05, 26'h600, 3'd0, 64'd0);
        expectAcq(7'h27, 26'h610, 3'd0, 64'd0);
        applyStimulus(1, 5'd7, 26'h610, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        applyStimulus(0, 5'd5, 26'h600, 3'd0, 1'b1, {13'd0, A_GET}, 64'd0);
        waitAccept(0); clearReq(0);
        waitAccept(1); clearReq(1);
        repeat (3) stepClk();

        checkOutput("acq_queue_empty", 64'(expAcq.size()), 64'd0);
        checkOutput("rsp_queue_empty", 64'(expRsp.size()), 64'd0);
        checkOutput("fin_queue_empty", 64'(expFin.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
